// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: start-up hold, taken branches, multi-cycle load stalls,
// halt and PC run-off, plus a saturating retired-instruction counter.
module fetch_ctrl #(
  parameter int unsigned LOAD_LAT = 2,
  parameter logic [7:0]  MAX_PC   = 8'hFF
) (
  input  logic        CLK,
  input  logic        Init,
  input  logic        Start,
  input  logic [7:0]  PC,
  input  logic [8:0]  Instr,
  input  logic        Zero,
  output logic        Branch,
  output logic [2:0]  Target,
  output logic        Stall,
  output logic        done,
  output logic        Retire,
  output logic [15:0] InstrCount
);

  typedef enum logic [1:0] {IDLE, RUN, LOAD_WAIT, HALT} state_t;

  localparam logic [3:0] LOAD_INIT = 4'(LOAD_LAT - 1);

  state_t     state, state_next;
  logic [3:0] load_cnt, load_cnt_next;
  logic       load_done, load_done_next;
  logic       is_halt, is_branch, is_load, taken;

  always_comb begin
    is_halt   = (Instr == 9'h1FF);
    is_branch = (Instr[8:6] == 3'b111) && !is_halt;
    is_load   = (Instr[8:6] == 3'b110);
    case (Instr[5:3])
      3'b000:  taken = 1'b1;
      3'b001:  taken = Zero;
      3'b010:  taken = !Zero;
      default: taken = 1'b0;
    endcase
  end

  // load_done marks the cycle right after a load finished stalling, so the
  // still-visible load is passed through instead of being issued again.
  always_comb begin
    state_next     = state;
    load_cnt_next  = load_cnt;
    load_done_next = 1'b0;
    Branch         = 1'b0;
    Target         = 3'd0;
    Stall          = 1'b1;
    done           = 1'b0;
    Retire         = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_next = RUN;
      end
      RUN: begin
        if (is_halt || (PC == MAX_PC)) begin
          done       = 1'b1;
          Retire     = 1'b1;
          state_next = HALT;
        end else if (is_branch && taken) begin
          Branch = 1'b1;
          Target = Instr[2:0];
          Stall  = 1'b0;
          Retire = 1'b1;
        end else if (is_load && !load_done) begin
          Stall = 1'b1;
          if (LOAD_LAT == 1) begin
            load_done_next = 1'b1;
          end else begin
            load_cnt_next = LOAD_INIT;
            state_next    = LOAD_WAIT;
          end
        end else if (is_load) begin
          // Single-cycle loads have no LOAD_WAIT cycle to retire in, so they retire here.
          Stall  = 1'b0;
          Retire = (LOAD_LAT == 1);
        end else begin
          Stall  = 1'b0;
          Retire = 1'b1;
        end
      end
      LOAD_WAIT: begin
        if (load_cnt > 4'd1) begin
          load_cnt_next = load_cnt - 4'd1;
        end else begin
          Retire         = 1'b1;
          load_cnt_next  = 4'd0;
          load_done_next = 1'b1;
          state_next     = RUN;
        end
      end
      HALT: begin
        done = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state     <= IDLE;
      load_cnt  <= 4'd0;
      load_done <= 1'b0;
    end else begin
      state     <= state_next;
      load_cnt  <= load_cnt_next;
      load_done <= load_done_next;
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      InstrCount <= 16'd0;
    end else if (Retire && (InstrCount != 16'hFFFF)) begin
      InstrCount <= InstrCount + 16'd1;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Drives the control inputs of the PC/fetch stage: Branch, Target, Stall and done.
- Watches the fetched 9-bit instruction and the current PC, and decides which of these to assert.
- Handles start-up hold, taken branches, multi-cycle load stalls, halt, and PC run-off.
- Also keeps a saturating count of retired instructions for the testbench and performance reporting.

Parameters:
- LOAD_LAT, 2: total stall cycles for a load instruction. Legal range is 1 to 15.
- MAX_PC, 8'hFF: highest legal PC. Fetching MAX_PC while in RUN forces halt.

Ports:
- CLK  input  1  system clock; rising edge.
- Init  input  1  asynchronous, active-high reset.
- Start  input  1  level; leaves IDLE when sampled high.
- PC  input  8  current PC from the fetch stage.
- Instr  input  9  instruction at PC, from the combinational instruction ROM.
- Zero  input  1  ALU zero flag, valid during the cycle the branch is fetched.
- Branch  output  1  fetch stage loads Target<<5 at the next edge.
- Target  output  3  branch target field.
- Stall  output  1  fetch stage holds PC.
- done  output  1  program finished; PC frozen.
- Retire  output  1  pulses high in the cycle an instruction completes.
- InstrCount  output  16  retired-instruction count; saturates at 16'hFFFF.

Behaviour:
- Reset: Init high forces, immediately and asynchronously:
  - state = IDLE, load counter = 0, InstrCount = 0.
  - Stall=1, Branch=0, Target=0, done=0, Retire=0.
  - Reset asserted mid-load or mid-halt discards everything.
- Output timing:
  - Branch, Target, Stall, done and Retire are combinational from the current state and Instr/Zero/PC.
  - State, load counter and InstrCount are registered.
- Instruction decode (Instr[8:6] = class):
  - Halt: Instr == 9'h1FF. This check takes priority over the branch-class check.
  - Branch class: 3'b111.
    - Instr[5:3] = 000: unconditional.
    - Instr[5:3] = 001: taken if Zero=1.
    - Instr[5:3] = 010: taken if Zero=0.
    - Any other sub-op: not taken.
    - Target = Instr[2:0].
  - Load: 3'b110.
  - All others: single-cycle ops.
- IDLE:
  - Stall=1, Retire=0.
  - When Start is high at an edge, go to RUN.
- RUN, in priority order:
  1. Halt, or PC == MAX_PC:
     - Stall=1, done=1, Retire=1.
     - Go to HALT.
  2. Taken branch:
     - Branch=1, Target=Instr[2:0], Stall=0, Retire=1.
     - Stay in RUN; there is no bubble.
  3. Load:
     - Stall=1, Retire=0.
     - If LOAD_LAT == 1: next state RUN with the counter unchanged. The fetch stage sees the following cycle as a normal RUN cycle.
     - Otherwise: counter <= LOAD_LAT-1, go to LOAD_WAIT.
  4. Any other instruction, including an untaken branch:
     - Stall=0, Retire=1.
- LOAD_WAIT:
  - Instr/Zero are ignored.
  - Counter > 1: Stall=1, decrement the counter.
  - Counter == 1: Stall=1, Retire=1, go to RUN with counter 0. The next RUN cycle decodes the same load again.
  - To avoid re-issuing the load, RUN ignores the load class when the previous state was LOAD_WAIT. The instruction is treated as a plain op: Stall=0, no retire.
  - Net effect: a load holds PC for exactly LOAD_LAT cycles, retires once, and PC advances on the cycle after the last stall.
- HALT:
  - done=1, Stall=1, Branch=0, Retire=0.
  - Left only by reset.
  - Start is ignored.
- InstrCount increments on every edge where Retire=1, and holds at 16'hFFFF once it gets there.
- Branch and Stall are never high in the same cycle.

Test Plan:
- Reset then Start: Init pulse with CLK stopped. Outputs go Stall=1, InstrCount=0 immediately. After Start, sequence Instr=9'h000 for 3 cycles → Stall=0, Retire=1 each cycle, InstrCount=3.
- Branches: Instr=9'h1C5 (unconditional, target 5) → Branch=1, Target=5, Stall=0. Instr=9'h1CB with Zero=0 → Branch=0. Same with Zero=1 → Branch=1, Target=3. Sub-op 3'b011 → never taken.
- Load with LOAD_LAT=2: load in RUN → Stall high for exactly 2 cycles, Retire high in the second. The third cycle has Stall=0 with no Retire. InstrCount increases by 1. Repeat with LOAD_LAT=1 and LOAD_LAT=4 → 1 and 4 stall cycles.
- Halt: Instr=9'h1FF → done=1 and Stall=1 in the same cycle, done stays 1 for 20 cycles, toggling Start has no effect. Also PC=8'hFF with a plain op → done=1.
- Reset mid-operation: Init asserted in the second LOAD_WAIT cycle, and separately in HALT → IDLE, done=0, InstrCount=0, asynchronously.
- Saturation: force 65 540 retirements → InstrCount stops at 16'hFFFF, with no wrap to 0.
